fir_serial_mac: RTL
===================

Name: fir_serial_mac

Overview:
Parametrised, time-multiplexed FIR filter. It uses one multiply-accumulate unit that processes one tap per clock.
- Generalises the fixed 16-bit, 401-tap filter interface with configurable data, coefficient and output widths.
- Coefficients are writable at run time.
- Output is rounded and scaled; saturation is optional.
- Sits between the sample source and downstream DSP stages, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, input sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
OUT_W, 16, output sample width (signed)
TAPS, 401, filter length; any value >= 2, not restricted to powers of two
SHIFT, 15, arithmetic right shift applied to the accumulator before output; 0 is legal

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  in_sample is valid
in_ready  out  1  block accepts a sample this cycle
in_sample  in  DATA_W  input sample
out_valid  out  1  out_sample is valid
out_ready  in  1  downstream accepts out_sample
out_sample  out  OUT_W  filtered output
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index k (h[k] multiplies x[n-k])
coef_wdata  in  COEF_W  coefficient value
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst is asynchronous and active-low.
  - While rst=0: in_ready=0, out_valid=0, out_sample=0, busy=1; FSM is forced to CLEAR.
  - Any computation in progress is discarded.
- FSM states: CLEAR, IDLE, MAC, ROUND, OUT.
- CLEAR:
  - Runs for TAPS cycles after reset release.
  - Writes 0 to every delay-line and coefficient entry; write pointer is set to 0.
  - Then goes to IDLE.
- IDLE:
  - in_ready=1.
  - A sample is accepted when in_valid=1 and in_ready=1. It is written at wr_ptr, acc is cleared, k=0, and the FSM goes to MAC.
- MAC:
  - Lasts exactly TAPS cycles. Each cycle computes acc += x[(wr_ptr-k) mod TAPS] * h[k], for k = 0..TAPS-1.
  - wr_ptr advances on the last MAC cycle and wraps from TAPS-1 to 0.
  - Modulo indexing is explicit, so non-power-of-two TAPS is correct.
- ROUND (1 cycle):
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - r is then narrowed to OUT_W (see Optional Feature).
- OUT:
  - out_valid=1 and out_sample holds r, stable until out_ready=1.
  - On handshake: out_valid is deasserted in the next cycle and the FSM goes to IDLE.
- Latency and throughput:
  - Sample accepted on cycle t -> out_valid first high on cycle t+TAPS+2.
  - Minimum spacing between accepts is TAPS+3 cycles.
  - in_ready is high only in IDLE.
- Arithmetic widths:
  - Products are signed, DATA_W+COEF_W bits.
  - ACC_W = DATA_W+COEF_W+clog2(TAPS), so the accumulator cannot overflow.
- Coefficient writes:
  - Honoured only in IDLE; a write in any other state is silently dropped.
  - A write in the same IDLE cycle as a sample accept takes effect before that sample's MAC.
- Backpressure: out_ready=0 for any duration stalls the block in OUT. No input is accepted and the output does not change.
- Reset mid-operation: outputs drop immediately, no partial result is ever emitted, and CLEAR reruns.

Optional Feature:
FIR_SAT_EN
- Defined: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: out_sample = r[OUT_W-1:0] (two's-complement wrap).

Decomposition:
- Package fir_pkg holds:
  - clog2 function
  - FSM state encoding constants (CLEAR, IDLE, MAC, ROUND, OUT)
  - ACC_W derivation
  - saturate/round helper function
- One sub-module: fir_tap_ram, a parametrised one-write/one-read synchronous RAM (depth TAPS, width W). It is instantiated twice: delay line (DATA_W) and coefficients (COEF_W).
- The FSM, pointer logic and MAC stay in fir_serial_mac.

Test Plan:
All scenarios use TAPS=8, DATA_W=COEF_W=OUT_W=16.
1. Reset, then release -> in_ready=0 for exactly 8 cycles, then 1; out_valid=0 and out_sample=0 throughout.
2. SHIFT=0, h[k]=k+1; input 1 followed by nine 0s -> outputs 1,2,3,4,5,6,7,8,0,0; each out_valid rises exactly 10 cycles after its accept.
3. Same setup with out_ready held 0 for 5 cycles during OUT -> out_sample stable, in_ready=0, busy=1; the next sample is accepted only after the handshake, and no output is lost or duplicated.
4. SHIFT=15, all h=0x7FFF, eight inputs of 0x7FFF -> 8th output is 0x7FFF with FIR_SAT_EN defined, and 0xFFF0 without it (r=262128).
5. coef_we pulsed during MAC with h[0]=0x0100 -> ignored; the next result uses the old h[0]. The same write in IDLE takes effect on the next sample.
6. rst asserted on the 4th MAC cycle -> out_valid=0 and in_ready=0 immediately; after release, CLEAR reruns, and a subsequent impulse produces all-zero output until coefficients are reloaded.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR filter.
//   - clog2 / acc_w       : elaboration-time width helpers
//   - fir_state_e         : FSM state encoding
//   - round_shift         : round-half-up arithmetic right shift
//   - sat_narrow          : clamp to a signed output range
// The rounding and saturation helpers work on a CALC_W-bit signed value, so
// the accumulator width (DATA_W+COEF_W+clog2(TAPS)) must stay below CALC_W.
package fir_pkg;

  localparam int CALC_W = 64;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } fir_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic logic signed [CALC_W-1:0] round_shift(
    input logic signed [CALC_W-1:0] a,
    input int                       shift
  );
    logic signed [CALC_W-1:0] bias;
    if (shift == 0) return a;
    bias = 64'sd1 <<< (shift - 1);
    return (a + bias) >>> shift;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_narrow(
    input logic signed [CALC_W-1:0] r,
    input int                       out_w
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Stream and coefficient-write bundle for fir_serial_mac.
//   in_valid/in_ready/in_sample    : input sample handshake
//   out_valid/out_ready/out_sample : output sample handshake
//   coef_we/coef_addr/coef_wdata   : run-time coefficient write port
// master = the surrounding system (source, sink, coefficient loader);
// slave  = the filter.
interface fir_serial_mac_if
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int TAPS   = 401
);
  localparam int AW = clog2(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_sample;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;

  modport master (
    output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_sample
  );

  modport slave (
    input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_sample
  );

endinterface

// File: rtl/fir_tap_ram.sv
// One-write / one-read synchronous RAM used for the delay line and the
// coefficient store. Read data appears one clock after raddr is presented.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data
module fir_tap_ram
  import fir_pkg::*;
#(
  parameter int DEPTH = 401,
  parameter int W     = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate per clock, TAPS
// clocks per output sample, coefficients writable at run time.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (FSM restarts in CLEAR)
//   bus  : fir_serial_mac_if.slave - input/output handshakes, coef writes
//   busy : high whenever the FSM is not in IDLE
// Build option: define FIR_SAT_EN to clamp the output to the OUT_W range;
// otherwise the rounded result wraps to OUT_W bits.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int TAPS   = 401,
  parameter int SHIFT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  fir_serial_mac_if.slave  bus,
  output logic             busy
);

  localparam int AW     = clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_e              state_q, state_d;
  logic [AW-1:0]           k_q, k_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_sample_q, out_sample_d;

  logic                     x_we, h_we;
  logic [AW-1:0]            x_waddr, h_waddr;
  logic [DATA_W-1:0]        x_wdata;
  logic [COEF_W-1:0]        h_wdata;
  logic [AW-1:0]            tap_idx;
  logic [DATA_W-1:0]        x_rdata;
  logic [COEF_W-1:0]        h_rdata;
  logic signed [PROD_W-1:0] prod_p1;

  function automatic logic signed [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] a);
    logic signed [CALC_W-1:0] r;
    r = round_shift(CALC_W'(a), SHIFT);
`ifdef FIR_SAT_EN
    r = sat_narrow(r, OUT_W);
`endif
    return r[OUT_W-1:0];
  endfunction

  // Stage p0: tap addressing. x[(wr_ptr-k) mod TAPS] without relying on
  // power-of-two wrap of the pointer width.
  assign tap_idx = (k_q <= wr_ptr_q) ? (wr_ptr_q - k_q)
                                     : AW'(int'(wr_ptr_q) + TAPS - int'(k_q));

  fir_tap_ram #(.DEPTH(TAPS), .W(DATA_W), .AW(AW)) u_xline (
    .clk   (clk),
    .we    (x_we),
    .waddr (x_waddr),
    .wdata (x_wdata),
    .raddr (tap_idx),
    .rdata (x_rdata)
  );

  fir_tap_ram #(.DEPTH(TAPS), .W(COEF_W), .AW(AW)) u_coef (
    .clk   (clk),
    .we    (h_we),
    .waddr (h_waddr),
    .wdata (h_wdata),
    .raddr (k_q),
    .rdata (h_rdata)
  );

  // Stage p1: RAM outputs are one cycle behind the address, so the product
  // for tap k is accumulated while tap k+1 is being addressed. The last
  // product lands during ROUND.
  assign prod_p1 = PROD_W'($signed(x_rdata)) * PROD_W'($signed(h_rdata));

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wr_ptr_d     = wr_ptr_q;
    vld_p1_d     = 1'b0;
    acc_d        = acc_q;
    out_sample_d = out_sample_q;
    x_we         = 1'b0;
    x_waddr      = wr_ptr_q;
    x_wdata      = bus.in_sample;
    h_we         = 1'b0;
    h_waddr      = bus.coef_addr;
    h_wdata      = bus.coef_wdata;

    if (vld_p1_q) acc_d = acc_q + ACC_W'(prod_p1);

    case (state_q)
      ST_CLEAR: begin
        x_we     = 1'b1;
        x_waddr  = k_q;
        x_wdata  = '0;
        h_we     = 1'b1;
        h_waddr  = k_q;
        h_wdata  = '0;
        wr_ptr_d = '0;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ST_IDLE: begin
        // Coefficient and sample writes in the same cycle both commit
        // before the first MAC read.
        h_we = bus.coef_we;
        if (bus.in_valid) begin
          x_we    = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        vld_p1_d = 1'b1;
        if (k_q == LAST) begin
          k_d      = '0;
          wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
          state_d  = ST_ROUND;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      // Stage p2: final accumulate, round and narrow into the output register.
      ST_ROUND: begin
        out_sample_d = narrow(acc_d);
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      vld_p1_q     <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wr_ptr_q     <= wr_ptr_d;
      vld_p1_q     <= vld_p1_d;
      out_sample_q <= out_sample_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_sample = out_sample_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
